// File: rtl/uart_pkg.sv
// Shared constants for the UART transmitter: register address map,
// status bit positions and frame state encoding.
package uart_pkg;

    localparam logic [1:0] ADDR_STATUS  = 2'b00;
    localparam logic [1:0] ADDR_INTMASK = 2'b01;
    localparam logic [1:0] ADDR_DATA    = 2'b10;
    localparam logic [1:0] ADDR_BAUD    = 2'b11;

    localparam int ST_TXE  = 0;
    localparam int ST_BUSY = 1;
    localparam int ST_OVR  = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period generator: latches the divisor on restart and pulses bit_done
// on the last cycle of each PRESCALE*(divisor+1)-cycle bit period.
module uart_baud_gen #(
    parameter int PRESCALE = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       restart,
    input  logic [7:0] divisor,
    output logic       bit_done
);

    localparam int CW = $clog2(PRESCALE * 256);
    localparam int PW = CW + 1;

    logic [7:0]    div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] period;

    always_comb begin
        period   = PW'(PRESCALE) * (PW'(div_q) + PW'(1));
        bit_done = ({1'b0, cnt_q} == (period - PW'(1)));
        div_d    = div_q;
        cnt_d    = cnt_q + CW'(1);
        // The working divisor only changes at a frame load, so mid-frame
        // register writes cannot stretch or shrink the current frame.
        if (restart) begin
            div_d = divisor;
            cnt_d = '0;
        end else if (bit_done) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
            cnt_q <= '0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_core.sv
// Register-backed 8-bit UART transmitter with one holding buffer and
// masked-status interrupt. Define UART_TX_PARITY_EN for an even parity bit.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int PRESCALE = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    output logic       tx,
    output logic [7:0] status_out,
    output logic [7:0] intmask_out,
    output logic       irq
);

    uart_state_e state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        tx_q, tx_d;
    logic        ovr_q, ovr_d;
    logic [7:0]  intmask_q, intmask_d;
    logic [7:0]  divisor_q, divisor_d;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    logic load;
    logic wr_data;
    logic accept;
    logic bit_done;

    uart_baud_gen #(
        .PRESCALE(PRESCALE)
    ) u_baud (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (load),
        .divisor (divisor_q),
        .bit_done(bit_done)
    );

    always_comb begin
        load    = hold_full_q && ((state_q == IDLE) || ((state_q == STOP) && bit_done));
        wr_data = wr && (addr == ADDR_DATA);
        // A write on the edge the shifter drains the holding buffer is accepted.
        accept  = wr_data && (!hold_full_q || load);

        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        tx_d        = tx_q;
        ovr_d       = ovr_q;
        intmask_d   = intmask_q;
        divisor_d   = divisor_q;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif

        if (wr && (addr == ADDR_INTMASK)) intmask_d = wdata;
        if (wr && (addr == ADDR_BAUD))    divisor_d = wdata;
        if (wr && (addr == ADDR_STATUS) && wdata[ST_OVR]) ovr_d = 1'b0;
        if (wr_data && !accept)           ovr_d = 1'b1;

        if (load)   hold_full_d = 1'b0;
        if (accept) begin
            hold_d      = wdata;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Load overrides the IDLE/STOP outcome so back-to-back frames have no gap.
        if (load) begin
            state_d = START;
            shift_d = hold_q;
            tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d = ^hold_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            tx_q        <= 1'b1;
            ovr_q       <= 1'b0;
            intmask_q   <= '0;
            divisor_q   <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
            ovr_q       <= ovr_d;
            intmask_q   <= intmask_d;
            divisor_q   <= divisor_d;
`ifdef UART_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    always_comb begin
        status_out          = 8'h00;
        status_out[ST_TXE]  = !hold_full_q;
        status_out[ST_BUSY] = (state_q != IDLE);
        status_out[ST_OVR]  = ovr_q;
    end

    assign tx          = tx_q;
    assign intmask_out = intmask_q;
    assign irq         = |(status_out & intmask_q);

endmodule

// File: tb/tb_uart_tx_core.sv
// Scoreboard bench for uart_tx_core: expected frames are queued at write
// time and a line monitor checks every cycle of each frame on tx.
module tb_uart_tx_core;
    import uart_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       wr;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic       tx;
    logic [7:0] status_out;
    logic [7:0] intmask_out;
    logic       irq;

    typedef struct {
        logic [7:0] data;
        int         p;
        bit         b2b;
    } exp_t;

    exp_t q[$];
    int   total_cnt = 0;
    int   pass_cnt  = 0;
    bit   mon_en    = 1'b1;
    bit   mon_busy  = 1'b0;

    uart_tx_core #(.PRESCALE(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr         (wr),
        .addr       (addr),
        .wdata      (wdata),
        .tx         (tx),
        .status_out (status_out),
        .intmask_out(intmask_out),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Caller is at a negedge; consecutive calls produce back-to-back writes.
    task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
        wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] d, input int p, input bit b2b);
        exp_t e;
        e.data = d; e.p = p; e.b2b = b2b;
        q.push_back(e);
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((q.size() != 0 || mon_busy || status_out != 8'h01) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(n < limit), 32'd1);
    endtask

    // Line monitor: every cycle of a frame is compared against the expected level.
    initial begin : monitor
        int gap = 1000;
        forever begin
            @(negedge clk);
            if (!reset_n || !mon_en) begin
                gap = 1000;
                continue;
            end
            if (tx === 1'b1) begin
                gap++;
            end else if (q.size() == 0) begin
                chk("unexpected_frame_queue_size", 32'(q.size()), 32'd1);
                repeat (160) @(negedge clk);
                gap = 0;
            end else begin
                exp_t        e;
                int          errs;
                logic [7:0]  rx;
                logic        lvl;
                e        = q.pop_front();
                mon_busy = 1'b1;
                errs     = 0;
                rx       = 8'h00;
                if (e.b2b) chk("frame_idle_gap", 32'(gap), 32'd0);
                for (int i = 0; i < 10 * e.p; i++) begin
                    int b;
                    if (i > 0) @(negedge clk);
                    b = i / e.p;
                    if (b == 0)      lvl = 1'b0;
                    else if (b == 9) lvl = 1'b1;
                    else             lvl = e.data[b-1];
                    if (tx !== lvl) errs++;
                    if (b >= 1 && b <= 8 && (i % e.p) == (e.p / 2)) rx[b-1] = tx;
                end
                chk("frame_level_errors", 32'(errs), 32'd0);
                chk("frame_byte", {24'h0, rx}, {24'h0, e.data});
                mon_busy = 1'b0;
                gap = 0;
            end
        end
    end

    initial begin : stim
        int n;
        int changes;
        reset_n = 1'b0; wr = 1'b0; addr = 2'b00; wdata = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_status", 32'(status_out), 32'h01);
        chk("reset_intmask", 32'(intmask_out), 32'h00);
        chk("reset_irq", 32'(irq), 32'd0);
        reset_n = 1'b1;
        changes = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || status_out !== 8'h01 || irq !== 1'b0) changes++;
        end
        chk("idle_no_change", 32'(changes), 32'd0);

        // Single frame 0xA5 at P=16
        push_exp(8'hA5, 16, 1'b0);
        reg_write(ADDR_DATA, 8'hA5);
        chk("a5_status_after_write", 32'(status_out), 32'h00);
        @(negedge clk);
        chk("a5_status_at_load", 32'(status_out), 32'h03);
        chk("a5_tx_start", 32'(tx), 32'd0);
        n = 0;
        while (status_out[ST_BUSY] && n < 5000) begin
            n++;
            @(negedge clk);
        end
        chk("a5_busy_cycles", 32'(n), 32'd160);
        drain(2000);

        // Back-to-back frames
        push_exp(8'h55, 16, 1'b0);
        push_exp(8'h0F, 16, 1'b1);
        reg_write(ADDR_DATA, 8'h55);
        n = 0;
        while (!status_out[ST_TXE] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_txe_timeout", 32'(n < 100), 32'd1);
        reg_write(ADDR_DATA, 8'h0F);
        drain(2000);
        chk("b2b_no_ovr", 32'(status_out[ST_OVR]), 32'd0);

        // Overrun: third consecutive write is dropped
        push_exp(8'h11, 16, 1'b0);
        push_exp(8'h22, 16, 1'b1);
        reg_write(ADDR_DATA, 8'h11);
        reg_write(ADDR_DATA, 8'h22);
        reg_write(ADDR_DATA, 8'h33);
        chk("ovr_status", 32'(status_out), 32'h06);
        chk("ovr_irq_unmasked", 32'(irq), 32'd0);
        reg_write(ADDR_INTMASK, 8'h04);
        chk("ovr_irq_masked", 32'(irq), 32'd1);
        reg_write(ADDR_STATUS, 8'h04);
        chk("ovr_cleared_status", 32'(status_out), 32'h02);
        chk("ovr_cleared_irq", 32'(irq), 32'd0);
        drain(2000);
        repeat (300) @(negedge clk);
        chk("ovr_final_status", 32'(status_out), 32'h01);

        // Interrupt on TXE
        reg_write(ADDR_INTMASK, 8'h01);
        chk("irq_txe_idle", 32'(irq), 32'd1);
        push_exp(8'h3C, 16, 1'b0);
        reg_write(ADDR_DATA, 8'h3C);
        chk("irq_after_write", 32'(irq), 32'd0);
        @(negedge clk);
        chk("irq_at_load", 32'(irq), 32'd1);
        drain(2000);

        // Divisor change mid-frame takes effect on the next frame
        reg_write(ADDR_BAUD, 8'd3);
        push_exp(8'h81, 64, 1'b0);
        push_exp(8'hC3, 16, 1'b1);
        reg_write(ADDR_DATA, 8'h81);
        repeat (100) @(negedge clk);
        reg_write(ADDR_BAUD, 8'd0);
        reg_write(ADDR_DATA, 8'hC3);
        drain(4000);

        // Reset mid-frame abandons the frame
        mon_en = 1'b0;
        reg_write(ADDR_DATA, 8'hF0);
        repeat (70) @(negedge clk);
        chk("midframe_tx_low", 32'(tx), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("midreset_tx", 32'(tx), 32'd1);
        chk("midreset_status", 32'(status_out), 32'h01);
        chk("midreset_intmask", 32'(intmask_out), 32'h00);
        chk("midreset_irq", 32'(irq), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        changes = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx !== 1'b1 || status_out !== 8'h01) changes++;
        end
        chk("post_reset_quiet", 32'(changes), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

Register-backed 8-bit UART transmitter that sits directly downstream of the one-to-four register bus decoder. It uses the same 2-bit address map: status, intmask, data and baud-rate divisor. It holds those registers, serialises written data bytes onto `tx`, and raises an interrupt from masked status bits. It consists of a single holding buffer, a shift register, a frame state machine and a baud-tick generator.

## Interface
- `PRESCALE`, default 16: clock cycles per divisor unit. Bit period P = PRESCALE × (divisor + 1) cycles.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset_n`  input  1  reset, asynchronous and active-low; one clock.
- `wr`  input  1  write strobe; sampled on the rising edge.
- `addr`  input  2  register select: 00 status, 01 intmask, 10 data, 11 baud-rate divisor.
- `wdata`  input  8  write data.
- `tx`  output  1  serial line, idle high.
- `status_out`  output  8  current status byte. Bit0 TXE (holding empty), bit1 BUSY (shifter active), bit2 OVR (overrun, sticky), others 0.
- `intmask_out`  output  8  current intmask register.
- `irq`  output  1  |(status_out & intmask_out).

## Operation
- Registers:
  - intmask (8b): plain write.
  - divisor (8b): plain write.
  - status: only OVR is writable. Writing 1 to `wdata[2]` at addr 00 clears OVR; other bits are ignored.
- Data write (addr 10):
  - Holding empty: byte goes to holding and TXE clears.
  - Holding full: byte is discarded, OVR sets, holding is unchanged.
- Shifter load: in IDLE with holding full, the shifter loads from holding. On the same edge TXE sets, BUSY sets and state goes to START. The divisor is latched into a working copy at load; divisor writes mid-frame affect only the next frame.
- FSM states and transitions:
  - IDLE → START: on load.
  - START → DATA: after P cycles.
  - DATA: 8 bits, LSB first, each P cycles.
  - DATA → STOP.
  - STOP → START: when holding is full at the end of STOP; the next frame starts with no idle gap.
  - STOP → IDLE: otherwise. BUSY clears when entering IDLE.
- `tx` is registered: 1 in IDLE/STOP, 0 in START, data bit in DATA.
- Baud counter: width $clog2(PRESCALE×256). It counts 0..P−1 and resets to 0 on load and at each bit boundary.
- Simultaneous events:
  - Data write on the same edge the shifter empties holding: the write sees holding empty and is accepted; no OVR.
  - OVR set and OVR clear on the same edge: set wins.
  - Writes to any address are accepted in every state.

## Timing
- Reset values: `tx` = 1, `status_out` = 8'h01, `intmask_out` = 8'h00, `irq` = 0, divisor = 0, FSM IDLE, counters 0.
- Reset asserted mid-frame forces all of the above immediately; the frame is abandoned.
- Data write accepted at edge N with shifter idle:
  - holding loaded at N;
  - shifter load and `tx` falling to 0 at N+1;
  - TXE returns to 1 at N+1.
- Frame length: 10×P cycles; 11×P cycles with parity. BUSY is high for exactly that span for an isolated frame.
- `irq` is combinational from registered status and intmask, so it is valid the cycle after the causing edge.

## Configuration
- `UART_TX_PARITY_EN` defined: a PARITY state sits between DATA and STOP. It drives even parity (XOR of the 8 data bits) for P cycles; the frame is 11×P.
- Not defined: no PARITY state; the frame is 10×P. The register map is identical either way.

## Structure
- Package `uart_pkg` holds:
  - the address constants (ADDR_STATUS, ADDR_INTMASK, ADDR_DATA, ADDR_BAUD);
  - the status bit indices (ST_TXE, ST_BUSY, ST_OVR);
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP).
- Sub-module `uart_baud_gen` contains the divisor latch and bit-period counter. It has inputs `restart` and divisor, and outputs `bit_done`.

## Test plan
- Reset: hold `reset_n` low → `tx` = 1, `status_out` = 8'h01, `irq` = 0. Release, then idle 100 cycles → no change.
- Single frame: PRESCALE = 16, divisor 0, write 8'hA5 to addr 10 → `tx` sequence 0,1,0,1,0,0,1,0,1,1 with each level 16 cycles. BUSY is high for 160 cycles.
- Back-to-back: write 8'h55, then 8'h0F once TXE = 1 → the second start bit begins on the edge the first stop bit ends. OVR stays 0.
- Overrun: write 3 bytes in consecutive cycles → the third sets OVR (status 8'h06 while busy) and is never transmitted. Write 8'h04 to addr 00 → OVR clears.
- Interrupt: intmask 8'h01, write a byte → `irq` drops the cycle after the write edge and rises again at shifter load. With intmask 8'h04, `irq` follows OVR only.
- Divisor change and reset: divisor 3 (P = 64), change to 0 mid-frame → the frame stays at 64-cycle bits and the next frame uses 16. Assert `reset_n` mid-frame → `tx` = 1 immediately and status is 8'h01.
